vga_timing_gen: RTL

- Parametrised successor to the fixed 800x480 VGA controller. Generates HS/VS/BLANK/RGB for any panel timing, with configurable sync polarity.
- Selectable pixel source: grid, colour bars, pixel stream from a first-word-fall-through (FWFT) FIFO, or black. Adds underflow detection.
- Sits in the pixel_clk domain between the read-side of the frame-buffer async FIFO and the video_if master.

---
 rtl/vga_timing_gen.sv | 109 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing with grid/bars/FWFT-stream/black pixel sources and sticky underflow
module vga_timing_gen #(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int HFP = 40,
  parameter int HPULSE = 48,
  parameter int HBP = 40,
  parameter int VFP = 13,
  parameter int VPULSE = 3,
  parameter int VBP = 29,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0,
  parameter int GRID = 16,
  parameter logic [23:0] UNDER_RGB = 24'hFF00FF
) (
  input  logic pixel_clk,
  input  logic pixel_rst_n,
  input  logic [1:0] mode,
  input  logic [23:0] fifo_rdata,
  input  logic fifo_empty,
  output logic fifo_read,
  input  logic underflow_clr,
  output logic HS,
  output logic VS,
  output logic BLANK,
  output logic [23:0] RGB,
  output logic [$clog2(HDISP)-1:0] pix_x,
  output logic [$clog2(VDISP)-1:0] pix_y,
  output logic frame_start,
  output logic underflow
);
  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HOFF = HFP + HPULSE + HBP;
  localparam int VOFF = VFP + VPULSE + VBP;
  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [1:0] mode_q, mode_d;
  logic hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, fs_q, fs_d, uf_q, uf_d;
  logic [23:0] rgb_q, rgb_d;
  logic [XW-1:0] x_q, x_d, x;
  logic [YW-1:0] y_q, y_d, y;
  logic active, grid_on, origin;
  logic [2:0] bar;
  always_comb begin
    origin = h_q == '0 && v_q == '0;
    h_d = h_q == HW'(HTOTAL - 1) ? '0 : h_q + HW'(1);
    v_d = h_q != HW'(HTOTAL - 1) ? v_q : v_q == VW'(VTOTAL - 1) ? '0 : v_q + VW'(1);
    active = h_q >= HW'(HOFF) && v_q >= VW'(VOFF);
    x = XW'(h_q - HW'(HOFF));
    y = YW'(v_q - VW'(VOFF));
    bar = '0;
    for (int k = 1; k < 8; k++) if ({x, 3'b000} >= (XW + 3)'(k * HDISP)) bar = 3'(k);
    grid_on = (x & XW'(GRID - 1)) == '0 || (y & YW'(GRID - 1)) == '0;
    fifo_read = active && mode_q == 2'd2 && !fifo_empty;
    mode_d = origin ? mode : mode_q;
    hs_d = h_q >= HW'(HFP) && h_q < HW'(HFP + HPULSE) ? HS_POL : ~HS_POL;
    vs_d = v_q >= VW'(VFP) && v_q < VW'(VFP + VPULSE) ? VS_POL : ~VS_POL;
    blank_d = active;
    x_d = active ? x : '0;
    y_d = active ? y : '0;
    fs_d = origin;
    rgb_d = !active ? '0 :
            mode_q == 2'd0 ? (grid_on ? 24'hFFFFFF : 24'h000000) :
            mode_q == 2'd1 ? BARS[bar] :
            mode_q == 2'd2 ? (fifo_empty ? UNDER_RGB : fifo_rdata) : '0;
    uf_d = (active && mode_q == 2'd2 && fifo_empty) || (uf_q && !underflow_clr);
  end
  always_ff @(posedge pixel_clk or negedge pixel_rst_n)
    if (!pixel_rst_n) begin
      h_q <= '0;
      v_q <= '0;
      mode_q <= '0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      blank_q <= 1'b0;
      rgb_q <= '0;
      x_q <= '0;
      y_q <= '0;
      fs_q <= 1'b0;
      uf_q <= 1'b0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      mode_q <= mode_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      blank_q <= blank_d;
      rgb_q <= rgb_d;
      x_q <= x_d;
      y_q <= y_d;
      fs_q <= fs_d;
      uf_q <= uf_d;
    end
  assign HS = hs_q;
  assign VS = vs_q;
  assign BLANK = blank_q;
  assign RGB = rgb_q;
  assign pix_x = x_q;
  assign pix_y = y_q;
  assign frame_start = fs_q;
  assign underflow = uf_q;
endmodule
